// File: rtl/riscv_pkg.sv
// Shared encodings for the Memory/Writeback slice: result-select codes,
// load/store size codes and the load/store unit FSM state type.
package riscv_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_GNT = 2'b01,
        WAIT_RD  = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/floprc.sv
// Resettable flop with synchronous clear; clear loads zero (pipeline bubble).
module floprc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clear)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction
// and misalignment detection. Unsupported size codes behave as word accesses.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        mem_op,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic        is_byte;
    logic        is_half;
    logic [4:0]  shamt;
    logic [31:0] shifted;

    always_comb begin
        is_byte = (funct3 == F3_B) || (!is_store && funct3 == F3_BU);
        is_half = (funct3 == F3_H) || (!is_store && funct3 == F3_HU);
        shamt   = {addr_lo, 3'b000};
        shifted = load_word >> shamt;

        be        = 4'b1111;
        wdata     = store_data;
        rdata_ext = shifted;
        misalign  = 1'b0;

        if (is_byte) begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            rdata_ext = funct3[2] ? {24'd0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata     = {2{store_data[15:0]}};
            rdata_ext = funct3[2] ? {16'd0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            misalign  = mem_op && addr_lo[0];
        end else begin
            misalign  = mem_op && (addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/memory_writeback_cycle.sv
// Memory stage load/store unit with request/grant/rvalid handshake and the
// MEM/WB pipeline register feeding the register-file write port.
module memory_writeback_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic [2:0]      funct3M,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            MisalignM,
    output logic            RegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW
);

    lsu_state_t      state;
    logic            mem_op;
    logic            is_load;
    logic            misalign_raw;
    logic            bubble;
    logic [XLEN-1:0] load_ext;
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;

    assign mem_op  = MemWriteM || (ResultSrcM == RES_LOAD);
    assign is_load = !MemWriteM && (ResultSrcM == RES_LOAD);

    lsu_align u_align (
        .mem_op     (mem_op),
        .is_store   (MemWriteM),
        .funct3     (funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .load_word  (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .rdata_ext  (load_ext),
        .misalign   (misalign_raw)
    );

    assign dmem_addr = ALUResultM;
    assign dmem_we   = dmem_req && MemWriteM;

    // Handshake outputs are gated by rst so reset takes effect in the same cycle.
    always_comb begin
        dmem_req  = 1'b0;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE, WAIT_GNT: begin
                    MisalignM = (state == IDLE) && misalign_raw;
                    dmem_req  = mem_op && !misalign_raw;
                    StallM    = dmem_req && (is_load || !dmem_gnt);
                end
                WAIT_RD: StallM = !dmem_rvalid;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE, WAIT_GNT: begin
                    if (!dmem_req)
                        state <= IDLE;
                    else if (!dmem_gnt)
                        state <= WAIT_GNT;
                    else if (is_load)
                        state <= WAIT_RD;
                    else
                        state <= IDLE;
                end
                WAIT_RD: if (dmem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB boundary: stalls and misaligned accesses insert a bubble.
    assign bubble = StallM || MisalignM;

    floprc #(.WIDTH(1)) u_regwrite (
        .clk(clk), .rst(rst), .clear(bubble),
        .d(RegWriteM && (RdM != 5'd0)), .q(RegWriteW)
    );
    floprc #(.WIDTH(5)) u_rd (
        .clk(clk), .rst(rst), .clear(bubble), .d(RdM), .q(RdW)
    );
    floprc #(.WIDTH(2)) u_resultsrc (
        .clk(clk), .rst(rst), .clear(bubble), .d(ResultSrcM), .q(ResultSrcW)
    );
    floprc #(.WIDTH(XLEN)) u_aluresult (
        .clk(clk), .rst(rst), .clear(bubble), .d(ALUResultM), .q(ALUResultW)
    );
    floprc #(.WIDTH(XLEN)) u_readdata (
        .clk(clk), .rst(rst), .clear(bubble), .d(load_ext), .q(ReadDataW)
    );
    floprc #(.WIDTH(XLEN)) u_pcplus4 (
        .clk(clk), .rst(rst), .clear(bubble), .d(PCPlus4M), .q(PCPlus4W)
    );

    always_comb begin
        unique case (ResultSrcW)
            RES_LOAD: ResultW = ReadDataW;
            RES_PC4:  ResultW = PCPlus4W;
            default:  ResultW = ALUResultW;
        endcase
    end

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// Directed bench for memory_writeback_cycle: stores, loads, stalls,
// misalignment, reset mid-transaction and writeback result selection.
module tb_memory_writeback_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        MisalignM;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    int checks   = 0;
    int failures = 0;

    memory_writeback_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        RegWriteM   = 1'b0;
        ResultSrcM  = 2'b00;
        MemWriteM   = 1'b0;
        funct3M     = 3'b000;
        RdM         = 5'd0;
        ALUResultM  = 32'd0;
        WriteDataM  = 32'd0;
        PCPlus4M    = 32'd0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
    endtask

    task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        idle_in();
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        funct3M    = f3;
        ALUResultM = addr;
        RdM        = rd;
    endtask

    task automatic set_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        idle_in();
        MemWriteM  = 1'b1;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = data;
    endtask

    // Load granted at once, data returned one cycle later.
    task automatic load_txn(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        set_load(f3, addr, 5'd10);
        dmem_gnt = 1'b1;
        #1 chk({tag, "_stall0"}, StallM, 32'd1);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #1 chk({tag, "_stall1"}, StallM, 32'd0);
        tick();
        idle_in();
        chk({tag, "_regwrite"}, RegWriteW, 32'd1);
        chk({tag, "_result"}, ResultW, exp);
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        chk("rst_req", dmem_req, 32'd0);
        chk("rst_stall", StallM, 32'd0);
        chk("rst_misalign", MisalignM, 32'd0);
        chk("rst_regwrite", RegWriteW, 32'd0);
        chk("rst_rd", RdW, 32'd0);
        chk("rst_result", ResultW, 32'd0);
        rst = 1'b0;
        tick();

        // Plain ALU result passes through MEM/WB
        RegWriteM = 1'b1; RdM = 5'd3; ALUResultM = 32'h0000_1234;
        #1 chk("alu_req", dmem_req, 32'd0);
        chk("alu_stall", StallM, 32'd0);
        tick();
        idle_in();
        chk("alu_regwrite", RegWriteW, 32'd1);
        chk("alu_rd", RdW, 32'd3);
        chk("alu_result", ResultW, 32'h0000_1234);

        // SW with immediate grant
        set_store(3'b010, 32'h100, 32'hDEAD_BEEF);
        dmem_gnt = 1'b1;
        #1 chk("sw_req", dmem_req, 32'd1);
        chk("sw_we", dmem_we, 32'd1);
        chk("sw_addr", dmem_addr, 32'h100);
        chk("sw_be", dmem_be, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_stall", StallM, 32'd0);
        tick();
        chk("sw_regwrite", RegWriteW, 32'd0);

        // SB lane 1 and SH upper half
        set_store(3'b000, 32'h101, 32'h0000_00A5);
        dmem_gnt = 1'b1;
        #1 chk("sb_be", dmem_be, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        tick();
        set_store(3'b001, 32'h102, 32'h1234_BEEF);
        dmem_gnt = 1'b1;
        #1 chk("sh_be", dmem_be, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        tick();
        // Unsupported size code on a store acts as a word
        set_store(3'b011, 32'h104, 32'h0102_0304);
        dmem_gnt = 1'b1;
        #1 chk("sx_be", dmem_be, 32'hF);
        chk("sx_wdata", dmem_wdata, 32'h0102_0304);
        tick();

        // Store waits one cycle for grant
        set_store(3'b010, 32'h108, 32'h5555_AAAA);
        #1 chk("swg_stall0", StallM, 32'd1);
        tick();
        dmem_gnt = 1'b1;
        #1 chk("swg_req1", dmem_req, 32'd1);
        chk("swg_stall1", StallM, 32'd0);
        tick();
        idle_in();

        // LB 0x103, grant cycle 0, rvalid cycle 2
        set_load(3'b000, 32'h103, 5'd7);
        dmem_gnt = 1'b1;
        #1 chk("lb_req0", dmem_req, 32'd1);
        chk("lb_we0", dmem_we, 32'd0);
        chk("lb_be0", dmem_be, 32'h8);
        chk("lb_stall0", StallM, 32'd1);
        tick();
        dmem_gnt = 1'b0;
        #1 chk("lb_req1", dmem_req, 32'd0);
        chk("lb_stall1", StallM, 32'd1);
        tick();
        chk("lb_bubble", RegWriteW, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h8000_0000;
        #1 chk("lb_stall2", StallM, 32'd0);
        tick();
        idle_in();
        chk("lb_regwrite", RegWriteW, 32'd1);
        chk("lb_rd", RdW, 32'd7);
        chk("lb_result", ResultW, 32'hFFFF_FF80);

        // LHU 0x202 with grant withheld three cycles
        set_load(3'b101, 32'h202, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lhu_req_hold", dmem_req, 32'd1);
            chk("lhu_addr_hold", dmem_addr, 32'h202);
            chk("lhu_be_hold", dmem_be, 32'hC);
            chk("lhu_stall_hold", StallM, 32'd1);
            tick();
        end
        dmem_gnt = 1'b1;
        #1 chk("lhu_stall_gnt", StallM, 32'd1);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234;
        #1 chk("lhu_stall_rv", StallM, 32'd0);
        tick();
        idle_in();
        chk("lhu_regwrite", RegWriteW, 32'd1);
        chk("lhu_result", ResultW, 32'h0000_BEEF);

        load_txn("lh", 3'b001, 32'h200, 32'h0000_8001, 32'hFFFF_8001);
        load_txn("lbu", 3'b100, 32'h101, 32'h0000_F000, 32'h0000_00F0);
        load_txn("lw", 3'b010, 32'h204, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Misaligned LW: no request, one-cycle pulse, bubble
        set_load(3'b010, 32'h101, 5'd4);
        dmem_gnt = 1'b1;
        #1 chk("mis_req", dmem_req, 32'd0);
        chk("mis_pulse", MisalignM, 32'd1);
        chk("mis_stall", StallM, 32'd0);
        tick();
        idle_in();
        #1 chk("mis_pulse_end", MisalignM, 32'd0);
        chk("mis_regwrite", RegWriteW, 32'd0);
        set_store(3'b001, 32'h103, 32'h1);
        #1 chk("mis_sh", MisalignM, 32'd1);
        chk("mis_sh_req", dmem_req, 32'd0);
        tick();
        idle_in();

        // Reset while waiting for read data, then a late rvalid
        set_load(3'b010, 32'h300, 5'd6);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1 chk("rrd_stall", StallM, 32'd1);
        rst = 1'b1;
        #1 chk("rrd_req", dmem_req, 32'd0);
        chk("rrd_stall_rst", StallM, 32'd0);
        tick();
        rst = 1'b0;
        idle_in();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        #1 chk("rrd_late_stall", StallM, 32'd0);
        tick();
        idle_in();
        chk("rrd_regwrite", RegWriteW, 32'd0);

        // Link value to x0 is dropped, to x5 is written
        RegWriteM = 1'b1; ResultSrcM = 2'b10; RdM = 5'd0; PCPlus4M = 32'h44;
        tick();
        chk("jal_x0", RegWriteW, 32'd0);
        RdM = 5'd5;
        tick();
        chk("jal_x5_we", RegWriteW, 32'd1);
        chk("jal_x5_result", ResultW, 32'h44);
        ResultSrcM = 2'b11; ALUResultM = 32'h55; PCPlus4M = 32'h99;
        tick();
        idle_in();
        chk("src11_result", ResultW, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
